// File: rtl/ibex_wb_rf_write_stage.sv
// Writeback stage feeding the register-file write port: merges EX results and LSU load data.
// Latency: EX or LSU to rf_we_o is 1 cycle, 2 cycles when EX is parked in the skid entry.
// Backpressure: ex_ready_o drops while the skid entry is full or a second load waits for the first.
module ibex_wb_rf_write_stage #(
   parameter int unsigned DataWidth = 32,
   parameter bit          RV32E     = 1'b0
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,

   input  logic                 ex_valid_i,
   output logic                 ex_ready_o,
   input  logic                 ex_load_i,
   input  logic [4:0]           ex_rd_i,
   input  logic [DataWidth-1:0] ex_wdata_i,

   input  logic                 lsu_resp_valid_i,
   input  logic [DataWidth-1:0] lsu_rdata_i,
   input  logic                 lsu_err_i,

   output logic                 rf_we_o,
   output logic [4:0]           rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o,

   input  logic [4:0]           raddr_a_i,
   input  logic [4:0]           raddr_b_i,
   output logic                 fwd_a_valid_o,
   output logic                 fwd_b_valid_o,
   output logic [DataWidth-1:0] fwd_a_data_o,
   output logic [DataWidth-1:0] fwd_b_data_o,

   output logic                 load_hazard_o,
   output logic                 wb_err_o
);

   // Registered write port and error pulse
   logic                 rf_we_q,    rf_we_d;
   logic [4:0]           rf_waddr_q;
   logic [DataWidth-1:0] rf_wdata_q;
   logic                 wb_err_q,   wb_err_d;

   // One-entry skid buffer for an EX result that collides with load data
   logic                 skid_vld_q, skid_vld_d;
   logic [4:0]           skid_rd_q,  skid_rd_d;
   logic [DataWidth-1:0] skid_data_q, skid_data_d;

   // Single outstanding load tracker
   logic                 load_pend_q, load_pend_d;
   logic [4:0]           load_rd_q,   load_rd_d;

   // Handshake decode
   logic accept;
   logic acc_load;
   logic acc_alu;
   logic lsu_take;

   // Selected write source for this cycle
   logic                 sel_vld;
   logic [4:0]           sel_rd;
   logic [DataWidth-1:0] sel_data;
   logic                 sel_illegal;

   logic                 skid_fwd_ok;

   // A load waiting on the pending one may still go in the cycle its predecessor returns.
   assign ex_ready_o = !skid_vld_q && !(ex_load_i && load_pend_q && !lsu_resp_valid_i);
   assign accept     = ex_valid_i && ex_ready_o;
   assign acc_load   = accept && ex_load_i;
   assign acc_alu    = accept && !ex_load_i;

   // Only a non-faulting response to a tracked load actually occupies the write port.
   assign lsu_take   = lsu_resp_valid_i && load_pend_q && !lsu_err_i;

   // Pick one write source: load data, then the older skid entry, then a fresh EX result.
   always_comb begin
      sel_vld  = 1'b0;
      sel_rd   = '0;
      sel_data = '0;
      if (lsu_take) begin
         sel_vld  = 1'b1;
         sel_rd   = load_rd_q;
         sel_data = lsu_rdata_i;
      end else if (skid_vld_q) begin
         sel_vld  = 1'b1;
         sel_rd   = skid_rd_q;
         sel_data = skid_data_q;
      end else if (acc_alu) begin
         sel_vld  = 1'b1;
         sel_rd   = ex_rd_i;
         sel_data = ex_wdata_i;
      end
   end

   // x16..x31 do not exist in the embedded variant; such writes are dropped and reported.
   assign sel_illegal = RV32E && sel_rd[4];

   // Write enable and error pulse for the next cycle
   always_comb begin
      rf_we_d  = sel_vld && (sel_rd != 5'd0) && !sel_illegal;
      wb_err_d = (lsu_resp_valid_i && (!load_pend_q || lsu_err_i)) ||
                 (sel_vld && sel_illegal);
   end

   // Skid fills when EX collides with load data and drains on the first free cycle.
   always_comb begin
      skid_vld_d  = skid_vld_q;
      skid_rd_d   = skid_rd_q;
      skid_data_d = skid_data_q;
      if (acc_alu && lsu_take) begin
         skid_vld_d  = 1'b1;
         skid_rd_d   = ex_rd_i;
         skid_data_d = ex_wdata_i;
      end else if (skid_vld_q && !lsu_take) begin
         skid_vld_d  = 1'b0;
      end
   end

   // Any response retires the pending load; a load accepted in the same cycle re-arms it.
   always_comb begin
      load_pend_d = load_pend_q;
      load_rd_d   = load_rd_q;
      if (acc_load) begin
         load_pend_d = 1'b1;
         load_rd_d   = ex_rd_i;
      end else if (lsu_resp_valid_i) begin
         load_pend_d = 1'b0;
      end
   end

   // Write port and error state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         wb_err_q   <= 1'b0;
      end else begin
         rf_we_q  <= rf_we_d;
         wb_err_q <= wb_err_d;
         if (sel_vld) begin
            rf_waddr_q <= sel_rd;
            rf_wdata_q <= sel_data;
         end
      end
   end

   // Skid entry and load tracker state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         skid_vld_q  <= 1'b0;
         skid_rd_q   <= '0;
         skid_data_q <= '0;
         load_pend_q <= 1'b0;
         load_rd_q   <= '0;
      end else begin
         skid_vld_q  <= skid_vld_d;
         skid_rd_q   <= skid_rd_d;
         skid_data_q <= skid_data_d;
         load_pend_q <= load_pend_d;
         load_rd_q   <= load_rd_d;
      end
   end

   assign rf_we_o    = rf_we_q;
   assign rf_waddr_o = rf_waddr_q;
   assign rf_wdata_o = rf_wdata_q;
   assign wb_err_o   = wb_err_q;

   // A skid entry that will later be suppressed must not be forwarded either.
   assign skid_fwd_ok = skid_vld_q && (skid_rd_q != 5'd0) && !(RV32E && skid_rd_q[4]);

   // Port A forwarding: skid entry is younger than the write register, so it wins.
   always_comb begin
      fwd_a_valid_o = 1'b0;
      fwd_a_data_o  = '0;
      if (raddr_a_i != 5'd0) begin
         if (skid_fwd_ok && (skid_rd_q == raddr_a_i)) begin
            fwd_a_valid_o = 1'b1;
            fwd_a_data_o  = skid_data_q;
         end else if (rf_we_q && (rf_waddr_q == raddr_a_i)) begin
            fwd_a_valid_o = 1'b1;
            fwd_a_data_o  = rf_wdata_q;
         end
      end
   end

   // Port B forwarding, same priority as port A
   always_comb begin
      fwd_b_valid_o = 1'b0;
      fwd_b_data_o  = '0;
      if (raddr_b_i != 5'd0) begin
         if (skid_fwd_ok && (skid_rd_q == raddr_b_i)) begin
            fwd_b_valid_o = 1'b1;
            fwd_b_data_o  = skid_data_q;
         end else if (rf_we_q && (rf_waddr_q == raddr_b_i)) begin
            fwd_b_valid_o = 1'b1;
            fwd_b_data_o  = rf_wdata_q;
         end
      end
   end

   // Reading the register an outstanding load will write must stall in ID.
   assign load_hazard_o = load_pend_q && (load_rd_q != 5'd0) &&
                          ((raddr_a_i == load_rd_q) || (raddr_b_i == load_rd_q));

endmodule

// File: tb/tb_ibex_wb_rf_write_stage.sv
module tb_ibex_wb_rf_write_stage;

   logic        clk;
   logic        rst_n;
   logic        ex_valid, ex_load, lsu_resp_valid, lsu_err;
   logic [4:0]  ex_rd, raddr_a, raddr_b;
   logic [31:0] ex_wdata, lsu_rdata;

   logic        ex_ready, rf_we, fwd_a_valid, fwd_b_valid, load_hazard, wb_err;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata, fwd_a_data, fwd_b_data;

   logic        e_ex_ready, e_rf_we, e_fwd_a_valid, e_fwd_b_valid, e_load_hazard, e_wb_err;
   logic [4:0]  e_rf_waddr;
   logic [31:0] e_rf_wdata, e_fwd_a_data, e_fwd_b_data;

   int checks = 0;
   int errors = 0;
   int err_seen = 0;
   int err_exp = 0;
   logic [36:0] exp_q[$];

   ibex_wb_rf_write_stage #(.DataWidth(32), .RV32E(1'b0)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_load_i(ex_load),
      .ex_rd_i(ex_rd), .ex_wdata_i(ex_wdata),
      .lsu_resp_valid_i(lsu_resp_valid), .lsu_rdata_i(lsu_rdata), .lsu_err_i(lsu_err),
      .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
      .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
      .fwd_a_valid_o(fwd_a_valid), .fwd_b_valid_o(fwd_b_valid),
      .fwd_a_data_o(fwd_a_data), .fwd_b_data_o(fwd_b_data),
      .load_hazard_o(load_hazard), .wb_err_o(wb_err)
   );

   ibex_wb_rf_write_stage #(.DataWidth(32), .RV32E(1'b1)) dut_e (
      .clk_i(clk), .rst_ni(rst_n),
      .ex_valid_i(ex_valid), .ex_ready_o(e_ex_ready), .ex_load_i(ex_load),
      .ex_rd_i(ex_rd), .ex_wdata_i(ex_wdata),
      .lsu_resp_valid_i(lsu_resp_valid), .lsu_rdata_i(lsu_rdata), .lsu_err_i(lsu_err),
      .rf_we_o(e_rf_we), .rf_waddr_o(e_rf_waddr), .rf_wdata_o(e_rf_wdata),
      .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
      .fwd_a_valid_o(e_fwd_a_valid), .fwd_b_valid_o(e_fwd_b_valid),
      .fwd_a_data_o(e_fwd_a_data), .fwd_b_data_o(e_fwd_b_data),
      .load_hazard_o(e_load_hazard), .wb_err_o(e_wb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ex_valid = 1'b0; ex_load = 1'b0; ex_rd = 5'd0; ex_wdata = 32'd0;
      lsu_resp_valid = 1'b0; lsu_rdata = 32'd0; lsu_err = 1'b0;
   endtask

   // Monitor: every write seen on the port is checked against the scoreboard in order.
   always @(negedge clk) begin
      if (rf_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got x%0d=%0h expected no write", rf_waddr, rf_wdata);
         end else begin
            chk("wb_write", 64'({rf_waddr, rf_wdata}), 64'(exp_q.pop_front()));
         end
      end
      if (wb_err) err_seen++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      raddr_a = 5'd0; raddr_b = 5'd0;

      // Reset state
      @(negedge clk);
      chk("rst_rf_we", 64'(rf_we), 64'(0));
      chk("rst_waddr", 64'(rf_waddr), 64'(0));
      chk("rst_wdata", 64'(rf_wdata), 64'(0));
      chk("rst_wb_err", 64'(wb_err), 64'(0));
      chk("rst_hazard", 64'(load_hazard), 64'(0));
      chk("rst_ex_ready", 64'(ex_ready), 64'(1));
      tick();
      rst_n = 1'b1;

      // EX write x5
      ex_valid = 1'b1; ex_rd = 5'd5; ex_wdata = 32'hA5A5_0001; raddr_a = 5'd5;
      exp_q.push_back({5'd5, 32'hA5A5_0001});
      @(negedge clk);
      chk("ex_ready_idle", 64'(ex_ready), 64'(1));
      tick();
      idle_inputs();
      @(negedge clk);
      chk("fwd_a_valid_x5", 64'(fwd_a_valid), 64'(1));
      chk("fwd_a_data_x5", 64'(fwd_a_data), 64'(32'hA5A5_0001));
      tick();

      // Load x7, hazard, then collision with EX x3
      ex_valid = 1'b1; ex_load = 1'b1; ex_rd = 5'd7;
      tick();
      idle_inputs();
      raddr_a = 5'd0; raddr_b = 5'd7;
      @(negedge clk);
      chk("hazard_x7", 64'(load_hazard), 64'(1));
      tick();
      lsu_resp_valid = 1'b1; lsu_rdata = 32'h0000_1234;
      ex_valid = 1'b1; ex_rd = 5'd3; ex_wdata = 32'h0000_0055; raddr_a = 5'd3;
      exp_q.push_back({5'd7, 32'h0000_1234});
      exp_q.push_back({5'd3, 32'h0000_0055});
      @(negedge clk);
      chk("ex_ready_collide", 64'(ex_ready), 64'(1));
      tick();
      idle_inputs();
      @(negedge clk);
      chk("ex_ready_skid_full", 64'(ex_ready), 64'(0));
      chk("hazard_cleared", 64'(load_hazard), 64'(0));
      chk("fwd_b_x7", 64'({fwd_b_valid, fwd_b_data}), 64'({1'b1, 32'h0000_1234}));
      chk("fwd_a_skid_x3", 64'({fwd_a_valid, fwd_a_data}), 64'({1'b1, 32'h0000_0055}));
      tick();
      @(negedge clk);
      chk("ex_ready_drained", 64'(ex_ready), 64'(1));
      chk("fwd_a_wr_x3", 64'({fwd_a_valid, fwd_a_data}), 64'({1'b1, 32'h0000_0055}));
      tick();

      // Back-to-back loads x8 then x9
      ex_valid = 1'b1; ex_load = 1'b1; ex_rd = 5'd8;
      tick();
      ex_rd = 5'd9;
      @(negedge clk);
      chk("ex_ready_load_blk1", 64'(ex_ready), 64'(0));
      tick();
      @(negedge clk);
      chk("ex_ready_load_blk2", 64'(ex_ready), 64'(0));
      tick();
      lsu_resp_valid = 1'b1; lsu_rdata = 32'h0000_0088;
      exp_q.push_back({5'd8, 32'h0000_0088});
      @(negedge clk);
      chk("ex_ready_load_resp", 64'(ex_ready), 64'(1));
      tick();
      idle_inputs();
      raddr_a = 5'd0; raddr_b = 5'd9;
      @(negedge clk);
      chk("hazard_x9_rearmed", 64'(load_hazard), 64'(1));
      tick();

      // Faulting response for x9
      lsu_resp_valid = 1'b1; lsu_err = 1'b1; lsu_rdata = 32'hDEAD_BEEF;
      err_exp++;
      tick();
      idle_inputs();
      @(negedge clk);
      chk("fault_wb_err", 64'(wb_err), 64'(1));
      chk("fault_no_write", 64'(rf_we), 64'(0));
      chk("fault_hazard_clr", 64'(load_hazard), 64'(0));
      tick();
      @(negedge clk);
      chk("fault_err_one_cycle", 64'(wb_err), 64'(0));
      tick();

      // Write to x0 is dropped and x0 is never forwarded
      ex_valid = 1'b1; ex_rd = 5'd0; ex_wdata = 32'hFFFF_FFFF;
      raddr_a = 5'd0; raddr_b = 5'd0;
      tick();
      idle_inputs();
      @(negedge clk);
      chk("x0_no_write", 64'(rf_we), 64'(0));
      chk("x0_fwd_a", 64'({fwd_a_valid, fwd_a_data}), 64'(0));
      chk("x0_fwd_b", 64'({fwd_b_valid, fwd_b_data}), 64'(0));
      tick();

      // rd=20: legal on the full variant, dropped and flagged on RV32E
      ex_valid = 1'b1; ex_rd = 5'd20; ex_wdata = 32'h0000_2020;
      exp_q.push_back({5'd20, 32'h0000_2020});
      tick();
      idle_inputs();
      @(negedge clk);
      chk("rv32e_no_write", 64'(e_rf_we), 64'(0));
      chk("rv32e_err", 64'(e_wb_err), 64'(1));
      chk("rv32i_no_err", 64'(wb_err), 64'(0));
      tick();
      @(negedge clk);
      chk("rv32e_err_pulse", 64'(e_wb_err), 64'(0));
      tick();

      // Reset with the skid entry full
      ex_valid = 1'b1; ex_load = 1'b1; ex_rd = 5'd13;
      tick();
      idle_inputs();
      lsu_resp_valid = 1'b1; lsu_rdata = 32'h0000_1313;
      ex_valid = 1'b1; ex_rd = 5'd11; ex_wdata = 32'h0000_1111;
      raddr_a = 5'd11; raddr_b = 5'd0;
      exp_q.push_back({5'd13, 32'h0000_1313});
      tick();
      idle_inputs();
      @(negedge clk);
      chk("pre_rst_skid_full", 64'(ex_ready), 64'(0));
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rf_we", 64'(rf_we), 64'(0));
      chk("mid_rst_fwd_a", 64'({fwd_a_valid, fwd_a_data}), 64'(0));
      chk("mid_rst_ex_ready", 64'(ex_ready), 64'(1));
      tick();
      rst_n = 1'b1;
      tick();

      // Reset with a load pending, then a stray response
      ex_valid = 1'b1; ex_load = 1'b1; ex_rd = 5'd14;
      tick();
      idle_inputs();
      raddr_a = 5'd14;
      @(negedge clk);
      chk("pre_rst_hazard", 64'(load_hazard), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_hazard", 64'(load_hazard), 64'(0));
      tick();
      rst_n = 1'b1;
      lsu_resp_valid = 1'b1; lsu_rdata = 32'h0000_0777;
      err_exp++;
      tick();
      idle_inputs();
      @(negedge clk);
      chk("stray_err", 64'(wb_err), 64'(1));
      chk("stray_no_write", 64'(rf_we), 64'(0));
      tick();
      tick();
      tick();

      chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      chk("err_pulse_count", 64'(err_seen), 64'(err_exp));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
